// File: rtl/pic_bus_interface.sv
// ============================================================================
// Module  : pic_bus_interface
// Brief   : Clocked 8259A-style data-bus buffer with a read holding register,
//           poll-word reads and a write-capture strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_bus_interface #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SOURCES = 3,
    parameter int SEL_WIDTH   = 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              chip_select,
    input  logic                              read,
    input  logic                              write,
    input  logic                              address,
    input  logic [DATA_WIDTH-1:0]             data_bus_in,
    input  logic                              enable_read_register,
    input  logic [SEL_WIDTH-1:0]              register_select,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] read_sources,
    input  logic                              poll_armed,
    input  logic [DATA_WIDTH-1:0]             poll_word,
    input  logic                              out_control_logic_data,
    input  logic [DATA_WIDTH-1:0]             control_logic_data,
    output logic [DATA_WIDTH-1:0]             data_bus_out,
    output logic                              data_bus_drive,
    output logic                              write_strobe,
    output logic [DATA_WIDTH-1:0]             write_data,
    output logic                              write_address,
    output logic                              read_done,
    output logic                              poll_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [DATA_WIDTH-1:0]   r_hold;
    logic                    r_hold_valid;
    logic                    r_poll_flag;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic                    r_write_address;
    logic                    r_read_done;
    logic                    r_poll_ack;
    logic                    r_write_strobe;

    logic                    w_start_read;
    logic                    w_start_write;
    logic                    w_load_hold;
    logic                    w_capture;
    logic                    w_rd_end;
    logic                    w_wr_end;

    logic [SEL_WIDTH:0]      w_status_idx;
    logic                    w_status_ok;
    logic [DATA_WIDTH-1:0]   w_status_data;
    logic [DATA_WIDTH-1:0]   w_hold_data;
    logic                    w_hold_ok;
    logic [DATA_WIDTH-1:0]   w_bus_data;
    logic                    w_bus_drive;

    // Simultaneous read and write is illegal and simply keeps the block idle.
    assign w_start_read  = chip_select & read & ~write;
    assign w_start_write = chip_select & write & ~read;

    always_comb begin
        w_next      = r_state;
        w_load_hold = 1'b0;
        w_capture   = 1'b0;
        w_rd_end    = 1'b0;
        w_wr_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_read) begin
                    w_next      = ST_READ;
                    w_load_hold = 1'b1;
                end else if (w_start_write) begin
                    w_next    = ST_WRITE;
                    w_capture = 1'b1;
                end
            end
            ST_READ: begin
                if (!read || !chip_select) begin
                    w_next   = ST_IDLE;
                    w_rd_end = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!write || !chip_select) begin
                    w_next   = ST_IDLE;
                    w_wr_end = 1'b1;
                end else begin
                    w_capture = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status registers start at source 1; indices past the last source read as nothing.
    assign w_status_idx = {1'b0, register_select} + {{SEL_WIDTH{1'b0}}, 1'b1};
    assign w_status_ok  = (int'(w_status_idx) < NUM_SOURCES);

    always_comb begin
        w_status_data = '0;
        for (int k = 1; k < NUM_SOURCES; k++) begin
            if (int'(w_status_idx) == k) begin
                w_status_data = read_sources[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_hold_data = '0;
        w_hold_ok   = 1'b0;
        if (poll_armed) begin
            w_hold_data = poll_word;
            w_hold_ok   = 1'b1;
        end else if (address) begin
            w_hold_data = read_sources[0 +: DATA_WIDTH];
            w_hold_ok   = 1'b1;
        end else if (enable_read_register && w_status_ok) begin
            w_hold_data = w_status_data;
            w_hold_ok   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_hold          <= '0;
            r_hold_valid    <= 1'b0;
            r_poll_flag     <= 1'b0;
            r_write_data    <= '0;
            r_write_address <= 1'b0;
            r_read_done     <= 1'b0;
            r_poll_ack      <= 1'b0;
            r_write_strobe  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_read_done    <= w_rd_end;
            r_poll_ack     <= w_rd_end & r_poll_flag;
            r_write_strobe <= w_wr_end;
            if (w_load_hold) begin
                r_hold       <= w_hold_data;
                r_hold_valid <= w_hold_ok;
                r_poll_flag  <= poll_armed;
            end
            if (w_capture) begin
                r_write_data    <= data_bus_in;
                r_write_address <= address;
            end
        end
    end

    // The acknowledge vector overrides everything with no register in its path.
    always_comb begin
        w_bus_data  = '0;
        w_bus_drive = 1'b0;
        if (out_control_logic_data) begin
            w_bus_data  = control_logic_data;
            w_bus_drive = 1'b1;
        end else if ((r_state == ST_READ) && r_hold_valid) begin
            w_bus_data  = r_hold;
            w_bus_drive = 1'b1;
        end
    end

    assign data_bus_out   = w_bus_drive ? w_bus_data : {DATA_WIDTH{1'bz}};
    assign data_bus_drive = w_bus_drive;
    assign write_strobe   = r_write_strobe;
    assign write_data     = r_write_data;
    assign write_address  = r_write_address;
    assign read_done      = r_read_done;
    assign poll_ack       = r_poll_ack;

endmodule

`default_nettype wire

// File: tb/tb_pic_bus_interface.sv
// ============================================================================
// Module  : tb_pic_bus_interface
// Brief   : Scoreboard bench for pic_bus_interface (8-bit and 16-bit builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_bus_interface;

    typedef struct {
        logic [7:0] data;
        bit         drv;
        bit         poll;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       addr;
    } wr_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cs, rd, wr, a, en, pa, ocl;
    logic [0:0] sel;
    logic [7:0] din, mask, irr, isr, pw, cld;
    wire  [7:0] bus, wdata;
    wire        drv, wstb, wa, rdone, pack;

    logic        cs16, rd16, en16;
    logic [1:0]  sel16;
    logic [15:0] src16 [5];
    wire  [15:0] bus16, wdata16;
    wire         drv16, wstb16, wa16, rdone16, pack16;

    int n_tests = 0;
    int n_fail  = 0;

    rd_exp_t q_rd[$];
    wr_exp_t q_wr[$];

    pic_bus_interface #(.DATA_WIDTH(8), .NUM_SOURCES(3), .SEL_WIDTH(1)) u_dut (
        .clock(clk), .reset_n(rst_n), .chip_select(cs), .read(rd), .write(wr),
        .address(a), .data_bus_in(din), .enable_read_register(en),
        .register_select(sel), .read_sources({isr, irr, mask}),
        .poll_armed(pa), .poll_word(pw), .out_control_logic_data(ocl),
        .control_logic_data(cld), .data_bus_out(bus), .data_bus_drive(drv),
        .write_strobe(wstb), .write_data(wdata), .write_address(wa),
        .read_done(rdone), .poll_ack(pack)
    );

    pic_bus_interface #(.DATA_WIDTH(16), .NUM_SOURCES(5), .SEL_WIDTH(2)) u_dut16 (
        .clock(clk), .reset_n(rst_n), .chip_select(cs16), .read(rd16), .write(1'b0),
        .address(1'b0), .data_bus_in(16'h0000), .enable_read_register(en16),
        .register_select(sel16),
        .read_sources({src16[4], src16[3], src16[2], src16[1], src16[0]}),
        .poll_armed(1'b0), .poll_word(16'h0000), .out_control_logic_data(1'b0),
        .control_logic_data(16'h0000), .data_bus_out(bus16), .data_bus_drive(drv16),
        .write_strobe(wstb16), .write_data(wdata16), .write_address(wa16),
        .read_done(rdone16), .poll_ack(pack16)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: remembers what the bus showed during the read, scores it on read_done.
    logic [7:0] obs_d;
    logic       obs_drv;
    always @(posedge clk) begin
        #1;
        if (cs && rd && !wr) begin
            obs_d   = bus;
            obs_drv = drv;
        end
        if (rdone) begin
            if (q_rd.size() > 0) begin
                rd_exp_t e;
                e = q_rd.pop_front();
                check_val("sb_rd_drive", {31'd0, obs_drv}, {31'd0, e.drv});
                if (e.drv) check_val("sb_rd_data", {24'd0, obs_d}, {24'd0, e.data});
                check_val("sb_poll_ack", {31'd0, pack}, {31'd0, e.poll});
            end else begin
                check_val("sb_rd_unexpected", {31'd0, rdone}, 32'd0);
            end
        end
        if (pack && !rdone) check_val("sb_poll_ack_alone", {31'd0, pack}, 32'd0);
        if (wstb) begin
            if (q_wr.size() > 0) begin
                wr_exp_t w;
                w = q_wr.pop_front();
                check_val("sb_wr_data", {24'd0, wdata}, {24'd0, w.data});
                check_val("sb_wr_addr", {31'd0, wa}, {31'd0, w.addr});
            end else begin
                check_val("sb_wr_unexpected", {31'd0, wstb}, 32'd0);
            end
        end
    end

    task automatic do_read(input string tag, input logic ia, input logic ien, input logic isel,
                           input logic ipa, input logic [7:0] exp, input bit exp_drv,
                           input int cycles, input bit frz);
        q_rd.push_back('{data: exp, drv: exp_drv, poll: ipa});
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; a = ia; en = ien; sel = isel; pa = ipa;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_drive"}, {31'd0, drv}, {31'd0, exp_drv});
            if (exp_drv) check_val({tag, "_bus"}, {24'd0, bus}, {24'd0, exp});
            if (frz && i == 0) begin
                @(negedge clk);
                irr = 8'hFF;
            end
        end
        @(negedge clk);
        rd = 1'b0; pa = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_done"}, {31'd0, rdone}, 32'd1);
        check_val({tag, "_released"}, {31'd0, drv}, 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_done_fall"}, {31'd0, rdone}, 32'd0);
        @(negedge clk);
        cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cs = 0; rd = 0; wr = 0; a = 0; en = 0; pa = 0; ocl = 0; sel = '0;
        din = 8'h00; mask = 8'hA5; irr = 8'h05; isr = 8'h40; pw = 8'h83; cld = 8'h48;
        cs16 = 0; rd16 = 0; en16 = 0; sel16 = '0;
        for (int k = 0; k < 5; k++) src16[k] = 16'h1000 + 16'(k);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_drive", {31'd0, drv}, 32'd0);
        check_val("rst_wdata", {24'd0, wdata}, 32'd0);
        check_val("rst_waddr", {31'd0, wa}, 32'd0);
        check_val("rst_pulses", {29'd0, wstb, rdone, pack}, 32'd0);
        check_val("rst_drive16", {31'd0, drv16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_read("freeze", 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 3, 1'b1);
        irr = 8'h05;
        do_read("mask",   1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 2, 1'b0);
        do_read("isr",    1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b1, 2, 1'b0);
        do_read("no_en",  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0);
        do_read("poll",   1'b1, 1'b1, 1'b0, 1'b1, 8'h83, 1'b1, 2, 1'b0);
        do_read("single", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1, 1'b0);

        // Three-cycle write, last value wins.
        q_wr.push_back('{data: 8'h1F, addr: 1'b0});
        @(negedge clk); cs = 1; wr = 1; a = 0; din = 8'h13;
        @(negedge clk); din = 8'h17;
        @(negedge clk); din = 8'h1F;
        @(negedge clk); wr = 0; din = 8'h00;
        @(posedge clk); #1;
        check_val("wr_strobe", {31'd0, wstb}, 32'd1);
        @(posedge clk); #1;
        check_val("wr_strobe_fall", {31'd0, wstb}, 32'd0);
        check_val("wr_data_held", {24'd0, wdata}, 32'h1F);

        // Write ended by chip_select dropping.
        q_wr.push_back('{data: 8'h5A, addr: 1'b1});
        @(negedge clk); cs = 1; wr = 1; a = 1; din = 8'h5A;
        @(negedge clk); cs = 0;
        @(posedge clk); #1;
        check_val("wr_cs_strobe", {31'd0, wstb}, 32'd1);
        @(negedge clk); wr = 0; a = 0;

        // Illegal read+write: nothing happens.
        @(negedge clk); cs = 1; rd = 1; wr = 1; a = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("illegal_quiet", {29'd0, drv, rdone, wstb}, 32'd0);
        end
        @(negedge clk); rd = 0; wr = 0;
        @(posedge clk); #1;
        check_val("illegal_after", {30'd0, rdone, wstb}, 32'd0);
        @(negedge clk); cs = 0;

        // Override in IDLE is combinational.
        @(negedge clk); ocl = 1;
        #1;
        check_val("ovr_idle_bus", {24'd0, bus}, 32'h48);
        check_val("ovr_idle_drv", {31'd0, drv}, 32'd1);
        ocl = 0;
        #1;
        check_val("ovr_idle_off", {31'd0, drv}, 32'd0);

        // Override during READ, then back to held data.
        q_rd.push_back('{data: 8'hA5, drv: 1'b1, poll: 1'b0});
        @(negedge clk); cs = 1; rd = 1; a = 1;
        @(posedge clk); #1;
        check_val("ovr_rd_before", {24'd0, bus}, 32'hA5);
        #1; ocl = 1;
        #1;
        check_val("ovr_rd_bus", {24'd0, bus}, 32'h48);
        ocl = 0;
        #1;
        check_val("ovr_rd_after", {24'd0, bus}, 32'hA5);
        @(negedge clk); rd = 0;
        @(posedge clk); #1;
        check_val("ovr_rd_done", {31'd0, rdone}, 32'd1);
        @(negedge clk); cs = 0;

        // Reset mid-read: immediate release, no read_done.
        @(negedge clk); cs = 1; rd = 1; a = 1;
        @(posedge clk); #1;
        check_val("rstrd_drive_pre", {31'd0, drv}, 32'd1);
        #1; rst_n = 0;
        #1;
        check_val("rstrd_drive", {31'd0, drv}, 32'd0);
        @(negedge clk); rd = 0; cs = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rstrd_no_done", {30'd0, rdone, pack}, 32'd0);
        end

        // Reset mid-write: no write_strobe.
        @(negedge clk); cs = 1; wr = 1; din = 8'h77;
        @(posedge clk); #2; rst_n = 0;
        @(negedge clk); wr = 0; cs = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rstwr_no_strobe", {31'd0, wstb}, 32'd0);
        end

        // 16-bit, five-source build: select source 4 and freeze it.
        src16[4] = 16'h1234;
        @(negedge clk); cs16 = 1; rd16 = 1; en16 = 1; sel16 = 2'd3;
        @(posedge clk); #1;
        check_val("w16_bus", {16'd0, bus16}, 32'h1234);
        check_val("w16_drive", {31'd0, drv16}, 32'd1);
        @(negedge clk); src16[4] = 16'hBEEF;
        @(posedge clk); #1;
        check_val("w16_frozen", {16'd0, bus16}, 32'h1234);
        @(negedge clk); rd16 = 0;
        @(posedge clk); #1;
        check_val("w16_done", {31'd0, rdone16}, 32'd1);
        check_val("w16_released", {31'd0, drv16}, 32'd0);
        @(posedge clk); #1;
        check_val("w16_done_fall", {31'd0, rdone16}, 32'd0);
        @(negedge clk); cs16 = 0;

        repeat (2) @(posedge clk);
        #2;
        check_val("sb_rd_drained", q_rd.size(), 32'd0);
        check_val("sb_wr_drained", q_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pic_bus_interface.md
# pic_bus_interface

Parametrised, clocked successor to the 8259A data-bus buffer. It samples CPU read/write strobes on the system clock and freezes the selected read source in a holding register for the whole read pulse. It also serves poll-word reads and captures write cycles into a one-cycle write strobe for the control logic. The block sits between the external data bus and the control logic, mask, IRR and ISR registers; interrupt-acknowledge vectors bypass the holding register.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the data bus and of every source register.
- NUM_SOURCES, 3, number of readable registers. Source 0 is the mask register; sources 1..NUM_SOURCES-1 are the status registers (1 = IRR, 2 = ISR by default). Legal range 2..16.
- SEL_WIDTH, 1, width of `register_select`; must satisfy 2^SEL_WIDTH >= NUM_SOURCES-1.

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- chip_select  in  1  active-high; read and write are ignored while low.
- read  in  1  active-high CPU read strobe, synchronous to `clock`.
- write  in  1  active-high CPU write strobe, synchronous to `clock`.
- address  in  1  A0. When 1, a read selects source 0.
- data_bus_in  in  DATA_WIDTH  write data from the CPU.
- enable_read_register  in  1  when 1, an A0=0 read returns a status register.
- register_select  in  SEL_WIDTH  status register index; the source read is 1 + register_select.
- read_sources  in  NUM_SOURCES*DATA_WIDTH  concatenated sources; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- poll_armed  in  1  when 1, the next read returns `poll_word`.
- poll_word  in  DATA_WIDTH  poll response: I-bit plus encoded level.
- out_control_logic_data  in  1  acknowledge-vector override.
- control_logic_data  in  DATA_WIDTH  acknowledge vector.
- data_bus_out  out  DATA_WIDTH  bus data; all bits 'z' when not driving.
- data_bus_drive  out  1  1 while `data_bus_out` is driven.
- write_strobe  out  1  one-cycle pulse at the end of a write.
- write_data  out  DATA_WIDTH  captured write data; held until the next capture.
- write_address  out  1  captured A0; held until the next capture.
- read_done  out  1  one-cycle pulse at the end of a read.
- poll_ack  out  1  one-cycle pulse at the end of a read that returned `poll_word`. The control logic uses it to disarm polling.

## Operation

- State machine with three states: IDLE, READ, WRITE. The state, the holding register and a `hold_valid` bit are all registered.
- In IDLE:
  - `chip_select & read & ~write` moves to READ. The holding register loads, in priority order: `poll_word` if `poll_armed`; else source 0 if `address`; else source 1+`register_select` if `enable_read_register` and that index < NUM_SOURCES; else nothing, with `hold_valid` = 0. The poll flag is latched at the same time.
  - `chip_select & write & ~read` moves to WRITE and captures `data_bus_in` and `address`. The capture repeats every cycle while in WRITE, so the last value wins.
  - `read & write` together is illegal: the block stays in IDLE and produces no pulses.
- In READ:
  - The holding register is frozen; source changes are not visible.
  - When `read` is sampled low, or `chip_select` is sampled low, the block returns to IDLE, pulses `read_done`, and pulses `poll_ack` if the poll flag was latched.
  - `write` is ignored while in READ.
- In WRITE:
  - When `write` is sampled low, or `chip_select` is sampled low, the block returns to IDLE and pulses `write_strobe` with `write_data` and `write_address` valid.
  - `read` is ignored while in WRITE.
- Output selection (combinational, in priority order):
  1. `out_control_logic_data` = 1: drive `control_logic_data`, regardless of state.
  2. Otherwise, state == READ and `hold_valid` = 1: drive the holding register.
  3. Otherwise: drive 'z' and set `data_bus_drive` = 0.

## Timing

- Reset values: state IDLE, holding register 0, `hold_valid` 0, `write_data` 0, `write_address` 0, all pulses 0, `data_bus_out` 'z', `data_bus_drive` 0.
- Reset is asynchronous and may arrive mid-read or mid-write. The bus releases immediately and no `read_done`, `poll_ack` or `write_strobe` pulse is produced.
- Read latency: `read` is sampled high at edge N, and the data is driven from edge N until edge M, the first edge at which `read` is sampled low. `read_done` is high for the cycle M→M+1.
- A read lasting a single cycle is legal: the data is driven for one cycle.
- Write: `write_strobe` is high for exactly the one cycle after the first edge at which `write` is sampled low.
- Back-to-back operations: the cycle after a strobe drops, the block is in IDLE and may accept a new read or write at that same edge.
- The acknowledge-vector override is purely combinational, with zero latency.

## Test plan

- Reset: assert `reset_n` = 0 mid-read → the bus goes 'z' and `data_bus_drive` = 0 at once; after release, no `read_done` pulse appears.
- Freeze during read: `address` = 0, `enable_read_register` = 1, `register_select` = 0, IRR = 8'h05; raise `read`, then change IRR to 8'hFF mid-pulse → the bus holds 8'h05. `read_done` pulses once after `read` falls.
- Mask and ISR reads: with `address` = 1 and mask = 8'hA5 → 8'hA5. With `address` = 0, select = 1 and ISR = 8'h40 → 8'h40. With `address` = 0, `enable_read_register` = 0 → 'z' throughout.
- Poll: `poll_armed` = 1, `poll_word` = 8'h83, `address` = 1 → the bus shows 8'h83 (not the mask). `poll_ack` and `read_done` pulse in the same cycle.
- Write: hold `write` for 3 cycles with data 8'h13 → 8'h17 → 8'h1F and `address` = 0 → one `write_strobe` pulse with `write_data` = 8'h1F and `write_address` = 0. `read` and `write` high together → no pulses.
- Override and parameters: `out_control_logic_data` = 1 with vector 8'h48 during an IDLE or READ state → 8'h48 immediately. Repeat the freeze scenario with DATA_WIDTH = 16 and NUM_SOURCES = 5, selecting source 4.
